dcache_ctrl: RTL

Data-cache controller for the pipelined MIPS core, placed between the MEM stage and the multi-cycle data memory. It holds a direct-mapped, write-through, no-write-allocate cache, answers load hits with zero wait states, and stalls the pipeline while it refills a line or writes a store through to memory. It also keeps hit and miss counters that benches use to check cache behaviour after a program run, such as the insertion-sort image.

---
 rtl/mips_cache_pkg.sv | 37 +++
 rtl/dcache_store.sv | 52 +++++
 rtl/dcache_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_cache_pkg.sv
// Shared types and address-field helpers for the MIPS data cache.
// Field widths here match the default 16-line, 4-word geometry.
package mips_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } cache_state_e;

  localparam int NUM_LINES_DEF      = 16;
  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int OFF_W = $clog2(WORDS_PER_LINE_DEF);
  localparam int IDX_W = $clog2(NUM_LINES_DEF);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  // Helpers return the field right-aligned in 32 bits; callers size-cast.
  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Combinational read; synchronous word and tag writes; only valid bits reset.
module dcache_store
  import mips_cache_pkg::*;
#(
  parameter int NUM_LINES      = NUM_LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  localparam int OW = $clog2(WORDS_PER_LINE),
  localparam int IW = $clog2(NUM_LINES),
  localparam int TW = 30 - OW - IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  input  logic [OW-1:0] rd_off,
  output logic [31:0]   rd_word,
  output logic [TW-1:0] rd_tag,
  output logic          rd_valid,
  input  logic [IW-1:0] wr_idx,
  input  logic          word_we,
  input  logic [OW-1:0] wr_off,
  input  logic [31:0]   wr_word,
  input  logic          tag_we,
  input  logic [TW-1:0] tag_wdata
);

  logic [31:0]          data_q [NUM_LINES*WORDS_PER_LINE];
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Arrays carry no reset; stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (word_we) data_q[{wr_idx, wr_off}] <= wr_word;
    if (tag_we)  tag_q[wr_idx]            <= tag_wdata;
  end

  assign rd_word  = data_q[{rd_idx, rd_off}];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// between the MEM stage and a multi-cycle word memory.
module dcache_ctrl
  import mips_cache_pkg::*;
#(
  parameter int NUM_LINES      = NUM_LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output cache_state_e state_dbg
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [OW-1:0] LAST_WORD = OW'(WORDS_PER_LINE - 1);

  // Handshakes: the CPU access completes in the cycle where cpu_req=1 and
  // stall=0. A memory word completes in the cycle where mem_req=1 and
  // mem_ready=1; mem_req/addr/we/wdata hold steady until that cycle.

  cache_state_e  state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [31:0]   hit_cnt_q, hit_cnt_d;
  logic [31:0]   miss_cnt_q, miss_cnt_d;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [31:0]   rd_word;
  logic [TW-1:0] rd_tag;
  logic          rd_valid;
  logic          hit;
  logic          word_we;
  logic [OW-1:0] wr_off;
  logic [31:0]   wr_word;
  logic          tag_we;
  logic          stall_c;

  assign off = OW'(addr_off(cpu_addr, OW));
  assign idx = IW'(addr_idx(cpu_addr, OW, IW));
  assign tag = TW'(addr_tag(cpu_addr, OW, IW));

  dcache_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_store (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx    (idx),
    .rd_off    (off),
    .rd_word   (rd_word),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_idx    (idx),
    .word_we   (word_we),
    .wr_off    (wr_off),
    .wr_word   (wr_word),
    .tag_we    (tag_we),
    .tag_wdata (tag)
  );

  assign hit = rd_valid && (rd_tag == tag);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall_c    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    word_we    = 1'b0;
    wr_off     = off;
    wr_word    = cpu_wdata;
    tag_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            stall_c = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            stall_c    = 1'b1;
            state_d    = REFILL;
            cnt_d      = '0;
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end
      end
      REFILL: begin
        stall_c  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag, idx, cnt_q, 2'b00};
        if (mem_ready) begin
          word_we = 1'b1;
          wr_off  = cnt_q;
          wr_word = mem_rdata;
          cnt_d   = cnt_q + 1'b1;
          // Tag and valid land only with the last word, so an abandoned
          // refill never exposes a partial line.
          if (cnt_q == LAST_WORD) begin
            tag_we  = 1'b1;
            state_d = RESP;
          end
        end
      end
      WRITE: begin
        stall_c   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[31:2], 2'b00};
        mem_wdata = cpu_wdata;
        if (mem_ready) begin
          word_we = hit;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // A pending load miss in IDLE would otherwise raise stall while reset is low.
  assign stall      = stall_c & reset;
  assign cpu_rdata  = rd_word;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign state_dbg  = state_q;

endmodule
